// File: rtl/reg_file_pkg.sv
// Shared types for the multi-port register file: default-width address/data
// typedefs and the write-op mnemonic used when printing transactions.
package reg_file_pkg;

  localparam int W = 32;
  localparam int D = 5;

  typedef logic [D-1:0] raddr_t;
  typedef logic [W-1:0] data_t;

  typedef enum logic {
    RF_HOLD  = 1'b0,
    RF_WRITE = 1'b1
  } rf_op_e;

endpackage

// File: rtl/reg_file_wsel.sv
// Write-port selector: for one address, reports whether any enabled write port
// targets it, the data of the highest-index such port, and a multi-writer flag.
module reg_file_wsel
  import reg_file_pkg::*;
#(
  parameter int W        = 32,
  parameter int D        = 5,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [NW-1:0]         write_en_i,
  input  logic [NW-1:0][D-1:0]  waddr_i,
  input  logic [NW-1:0][W-1:0]  data_in_i,
  input  logic [D-1:0]          addr_i,
  output logic                  hit_o,
  output logic [W-1:0]          data_o,
  output logic                  conflict_o
);

  logic hit;
  logic discard;

  // Writes to the hardwired zero register are not writes at all.
  assign discard = (ZERO_REG != 0) && (addr_i == '0);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments with every output
    // defaulted first, so later loop iterations see earlier ones and no latch is inferred.
    hit        = 1'b0;
    data_o     = '0;
    conflict_o = 1'b0;
    for (int p = 0; p < NW; p++) begin
      if (write_en_i[p] && (waddr_i[p] == addr_i) && !discard) begin
        if (hit) conflict_o = 1'b1;
        hit    = 1'b1;
        data_o = data_in_i[p];   // ascending scan: highest index wins
      end
    end
  end

  assign hit_o = hit;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised NR-read / NW-write register file with optional hardwired zero
// register, optional write-to-read bypass and a registered write-conflict flag.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int W        = 32,
  parameter int D        = 5,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NW-1:0]         write_en,
  input  logic [NW-1:0][D-1:0]  waddr,
  input  logic [NW-1:0][W-1:0]  data_in,
  input  logic [NR-1:0][D-1:0]  raddr,
  output logic [NR-1:0][W-1:0]  data_out,
  output logic                  wr_conflict
);

  localparam int DEPTH = 2 ** D;

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] wr_conf;
  logic [W-1:0]    wr_data [DEPTH];
  logic            wr_conflict_q;
  logic            wr_conflict_d;

  logic [NR-1:0]   rd_hit;
  logic [W-1:0]    rd_data [NR];
  logic [NR-1:0]   unused_rd_conflict;

  // Per-register write select: next value and same-cycle conflict bit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_wsel
    reg_file_wsel #(.W(W), .D(D), .NW(NW), .ZERO_REG(ZERO_REG)) u_wsel (
      .write_en_i (write_en),
      .waddr_i    (waddr),
      .data_in_i  (data_in),
      .addr_i     (D'(i)),
      .hit_o      (wr_hit[i]),
      .data_o     (wr_data[i]),
      .conflict_o (wr_conf[i])
    );
    assign mem_d[i] = wr_hit[i] ? wr_data[i] : mem_q[i];
  end

  assign wr_conflict_d = |wr_conf;

  always_ff @(posedge clk) begin
    // NOTE: the whole array is cleared on reset because software relies on
    // every register reading zero afterwards; state always uses non-blocking updates.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  // Bypass lookup per read port; its conflict output has no consumer.
  for (genvar r = 0; r < NR; r++) begin : g_rsel
    reg_file_wsel #(.W(W), .D(D), .NW(NW), .ZERO_REG(ZERO_REG)) u_rsel (
      .write_en_i (write_en),
      .waddr_i    (waddr),
      .data_in_i  (data_in),
      .addr_i     (raddr[r]),
      .hit_o      (rd_hit[r]),
      .data_o     (rd_data[r]),
      .conflict_o (unused_rd_conflict[r])
    );
  end

  always_comb begin
    data_out = '0;
    for (int r = 0; r < NR; r++) begin
      if ((ZERO_REG != 0) && (raddr[r] == '0))
        data_out[r] = '0;
      else if ((BYPASS != 0) && !reset && rd_hit[r])
        data_out[r] = rd_data[r];
      else
        data_out[r] = mem_q[raddr[r]];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance (zero reg, bypass) and a
// plain instance (no zero reg, no bypass) driven by the same stimulus.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic                 clk;
  logic                 reset;
  logic [1:0]           write_en;
  logic [1:0][4:0]      waddr;
  logic [1:0][31:0]     data_in;
  logic [1:0][4:0]      raddr;
  logic [1:0][31:0]     data_out;
  logic [1:0][31:0]     data_out_nb;
  logic                 wr_conflict;
  logic                 wr_conflict_nb;

  int n_vec = 0;
  int n_err = 0;

  reg_file_mp #(.W(32), .D(5), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .waddr       (waddr),
    .data_in     (data_in),
    .raddr       (raddr),
    .data_out    (data_out),
    .wr_conflict (wr_conflict)
  );

  reg_file_mp #(.W(32), .D(5), .NR(2), .NW(2), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .waddr       (waddr),
    .data_in     (data_in),
    .raddr       (raddr),
    .data_out    (data_out_nb),
    .wr_conflict (wr_conflict_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 2'b00;
    waddr    = '0;
    data_in  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    raddr = '0;
    tick();
    reset = 1'b0;
    raddr[0] = 5'd7;
    raddr[1] = 5'd31;
    #1;
    n_vec++;
    if (data_out[0] !== 32'h0) begin
      n_err++; $display("FAIL reset_rd7: got %h want %h", data_out[0], 32'h0);
    end
    n_vec++;
    if (data_out_nb[1] !== 32'h0) begin
      n_err++; $display("FAIL reset_rd31_nb: got %h want %h", data_out_nb[1], 32'h0);
    end
    n_vec++;
    if (wr_conflict !== 1'b0 || wr_conflict_nb !== 1'b0) begin
      n_err++; $display("FAIL reset_conflict: got %b/%b want 0/0", wr_conflict, wr_conflict_nb);
    end
  endtask

  task automatic test_write_read();
    rf_op_e op;
    write_en = 2'b01;
    waddr[0] = 5'd1;
    data_in[0] = 32'h6789ABCD;
    op = write_en[0] ? RF_WRITE : RF_HOLD;
    tick();
    idle();
    raddr[0] = 5'd1;
    #1;
    n_vec++;
    if (data_out[0] !== 32'h6789ABCD) begin
      n_err++; $display("FAIL write_read (%s): got %h want %h", op.name(), data_out[0], 32'h6789ABCD);
    end
    n_vec++;
    if (data_out_nb[0] !== 32'h6789ABCD) begin
      n_err++; $display("FAIL write_read_nb (%s): got %h want %h", op.name(), data_out_nb[0], 32'h6789ABCD);
    end
  endtask

  task automatic test_zero_reg();
    write_en = 2'b01;
    waddr[0] = 5'd0;
    data_in[0] = 32'hFEDC2030;
    raddr[1] = 5'd0;
    #1;
    n_vec++;
    if (data_out[1] !== 32'h0) begin
      n_err++; $display("FAIL zero_same_cycle: got %h want %h", data_out[1], 32'h0);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (data_out[1] !== 32'h0) begin
      n_err++; $display("FAIL zero_next_cycle: got %h want %h", data_out[1], 32'h0);
    end
    n_vec++;
    if (wr_conflict !== 1'b0) begin
      n_err++; $display("FAIL zero_conflict: got %b want 0", wr_conflict);
    end
    n_vec++;
    if (data_out_nb[1] !== 32'hFEDC2030) begin
      n_err++; $display("FAIL zero_ordinary_nb: got %h want %h", data_out_nb[1], 32'hFEDC2030);
    end
  endtask

  task automatic test_no_write();
    write_en = 2'b00;
    waddr[0] = 5'd2;
    data_in[0] = 32'h0000ABCD;
    raddr[0] = 5'd2;
    #1;
    n_vec++;
    if (data_out[0] !== 32'h0) begin
      n_err++; $display("FAIL nowrite_same: got %h want %h", data_out[0], 32'h0);
    end
    tick();
    n_vec++;
    if (data_out[0] !== 32'h0 || data_out_nb[0] !== 32'h0) begin
      n_err++; $display("FAIL nowrite_next: got %h/%h want 0/0", data_out[0], data_out_nb[0]);
    end
  endtask

  task automatic test_conflict();
    write_en = 2'b11;
    waddr[0] = 5'd3; data_in[0] = 32'h11111111;
    waddr[1] = 5'd3; data_in[1] = 32'h22222222;
    raddr[0] = 5'd3;
    #1;
    n_vec++;
    if (data_out[0] !== 32'h22222222) begin
      n_err++; $display("FAIL conflict_bypass: got %h want %h", data_out[0], 32'h22222222);
    end
    n_vec++;
    if (data_out_nb[0] !== 32'h0) begin
      n_err++; $display("FAIL conflict_old_nb: got %h want %h", data_out_nb[0], 32'h0);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (data_out[0] !== 32'h22222222 || data_out_nb[0] !== 32'h22222222) begin
      n_err++; $display("FAIL conflict_winner: got %h/%h want %h", data_out[0], data_out_nb[0], 32'h22222222);
    end
    n_vec++;
    if (wr_conflict !== 1'b1 || wr_conflict_nb !== 1'b1) begin
      n_err++; $display("FAIL conflict_flag: got %b/%b want 1/1", wr_conflict, wr_conflict_nb);
    end
    tick();
    n_vec++;
    if (wr_conflict !== 1'b0 || wr_conflict_nb !== 1'b0) begin
      n_err++; $display("FAIL conflict_not_sticky: got %b/%b want 0/0", wr_conflict, wr_conflict_nb);
    end
    // Different addresses: no conflict.
    write_en = 2'b11;
    waddr[0] = 5'd10; data_in[0] = 32'hA0A0A0A0;
    waddr[1] = 5'd11; data_in[1] = 32'hB1B1B1B1;
    tick();
    idle();
    n_vec++;
    if (wr_conflict !== 1'b0) begin
      n_err++; $display("FAIL distinct_addr_conflict: got %b want 0", wr_conflict);
    end
    // Both ports on reg 0: discarded with zero reg, real conflict without.
    write_en = 2'b11;
    waddr[0] = 5'd0; data_in[0] = 32'h1;
    waddr[1] = 5'd0; data_in[1] = 32'h2;
    tick();
    idle();
    n_vec++;
    if (wr_conflict !== 1'b0 || wr_conflict_nb !== 1'b1) begin
      n_err++; $display("FAIL zero_addr_conflict: got %b/%b want 0/1", wr_conflict, wr_conflict_nb);
    end
  endtask

  task automatic test_bypass();
    write_en = 2'b01;
    waddr[0] = 5'd5;
    data_in[0] = 32'hCAFEF00D;
    raddr[1] = 5'd5;
    #1;
    n_vec++;
    if (data_out[1] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL bypass_same: got %h want %h", data_out[1], 32'hCAFEF00D);
    end
    n_vec++;
    if (data_out_nb[1] !== 32'h0) begin
      n_err++; $display("FAIL nobypass_old: got %h want %h", data_out_nb[1], 32'h0);
    end
    tick();
    idle();
    #1;
    n_vec++;
    if (data_out_nb[1] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL nobypass_after_edge: got %h want %h", data_out_nb[1], 32'hCAFEF00D);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i < 32; i++) begin
      write_en = 2'b10;
      waddr[1] = 5'(i);
      data_in[1] = 32'(i);
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      raddr[0] = 5'(i);
      raddr[1] = 5'(i);
      #1;
      n_vec++;
      if (data_out[0] !== 32'(i) || data_out_nb[1] !== 32'(i)) begin
        n_err++; $display("FAIL fill_r%0d: got %h/%h want %h", i, data_out[0], data_out_nb[1], 32'(i));
      end
    end
    // Reset asserted together with a conflicting write to reg 9.
    reset = 1'b1;
    write_en = 2'b11;
    waddr[0] = 5'd9; data_in[0] = 32'hDEADBEEF;
    waddr[1] = 5'd9; data_in[1] = 32'hBEEFDEAD;
    raddr[0] = 5'd9;
    #1;
    n_vec++;
    if (data_out[0] !== 32'h9) begin
      n_err++; $display("FAIL reset_suppresses_bypass: got %h want %h", data_out[0], 32'h9);
    end
    tick();
    reset = 1'b0;
    idle();
    n_vec++;
    if (wr_conflict !== 1'b0 || wr_conflict_nb !== 1'b0) begin
      n_err++; $display("FAIL reset_drops_conflict: got %b/%b want 0/0", wr_conflict, wr_conflict_nb);
    end
    for (int i = 0; i < 32; i++) begin
      raddr[0] = 5'(i);
      raddr[1] = 5'(i);
      #1;
      n_vec++;
      if (data_out[0] !== 32'h0 || data_out_nb[1] !== 32'h0) begin
        n_err++; $display("FAIL cleared_r%0d: got %h/%h want 0", i, data_out[0], data_out_nb[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    write_en = '0;
    waddr = '0;
    data_in = '0;
    raddr = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_no_write();
    test_conflict();
    test_bypass();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
